// File: rtl/key_cursor_if.sv
// Key-cursor bus: keyboard events in, cursor/blink out, move offer via valid/ready.
interface key_cursor_if #(
  parameter int unsigned COORD_W = 4
);
  logic               en;
  logic [3:0]         key_code;
  logic               key_trick;
  logic               turn_en;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               cur_blink;
  logic               move_valid;
  logic [COORD_W-1:0] move_x;
  logic [COORD_W-1:0] move_y;
  logic               move_ready;

  // Upstream keyboard / game logic side.
  modport master (
    output en, key_code, key_trick, turn_en, move_ready,
    input  cur_x, cur_y, cur_blink, move_valid, move_x, move_y
  );

  // Cursor controller side.
  modport slave (
    input  en, key_code, key_trick, turn_en, move_ready,
    output cur_x, cur_y, cur_blink, move_valid, move_x, move_y
  );
endinterface

// File: rtl/key_cursor_ctrl.sv
// Gobang cursor controller: moves a board cursor from key events, offers a move
// to the game logic on confirm, and produces a cursor blink flag.
module key_cursor_ctrl #(
  parameter int unsigned BOARD_SIZE = 15,
  parameter int unsigned COORD_W    = 4,
  parameter logic [3:0]  KEY_UP     = 4'h2,
  parameter logic [3:0]  KEY_DOWN   = 4'h8,
  parameter logic [3:0]  KEY_LEFT   = 4'h4,
  parameter logic [3:0]  KEY_RIGHT  = 4'h6,
  parameter logic [3:0]  KEY_OK     = 4'h5,
  parameter logic [3:0]  KEY_HOME   = 4'h0,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input logic         clk_100M,
  input logic         rst_p,
  key_cursor_if.slave bus
);

  localparam logic [COORD_W-1:0] CENTER = COORD_W'(BOARD_SIZE / 2);
  localparam logic [COORD_W-1:0] MAX_C  = COORD_W'(BOARD_SIZE - 1);
  localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);
  localparam int unsigned        CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [0:0] {StEdit, StPending} state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] mx_q, mx_d, my_q, my_d;
  logic               valid_q, valid_d;
  logic               blink_q, blink_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trick_q;
  logic               key_evt;
  logic               restart;

  // State, cursor, move and blink registers; reset also aborts a pending offer.
  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      state_q <= StEdit;
      x_q     <= CENTER;
      y_q     <= CENTER;
      mx_q    <= '0;
      my_q    <= '0;
      valid_q <= 1'b0;
      blink_q <= 1'b1;
      cnt_q   <= '0;
      trick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      valid_q <= valid_d;
      blink_q <= blink_d;
      cnt_q   <= cnt_d;
      trick_q <= bus.key_trick;
    end
  end

  // Next-state: key decode in EDIT, handshake in PENDING, then blink timing.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mx_d    = mx_q;
    my_d    = my_q;
    valid_d = valid_q;
    blink_d = blink_q;
    cnt_d   = cnt_q;
    restart = 1'b0;
    key_evt = bus.key_trick & ~trick_q & bus.en;

    unique case (state_q)
      StEdit: begin
        if (key_evt) begin
          if (bus.key_code == KEY_LEFT) begin
            x_d     = (x_q == '0) ? MAX_C : x_q - ONE_C;
            restart = 1'b1;
          end else if (bus.key_code == KEY_RIGHT) begin
            x_d     = (x_q == MAX_C) ? '0 : x_q + ONE_C;
            restart = 1'b1;
          end else if (bus.key_code == KEY_UP) begin
            y_d     = (y_q == '0) ? MAX_C : y_q - ONE_C;
            restart = 1'b1;
          end else if (bus.key_code == KEY_DOWN) begin
            y_d     = (y_q == MAX_C) ? '0 : y_q + ONE_C;
            restart = 1'b1;
          end else if (bus.key_code == KEY_HOME) begin
            x_d     = CENTER;
            y_d     = CENTER;
            restart = 1'b1;
          end else if (bus.key_code == KEY_OK && bus.turn_en) begin
            mx_d    = x_q;
            my_d    = y_q;
            valid_d = 1'b1;
            state_d = StPending;
            restart = 1'b1;
          end
        end
      end
      StPending: begin
        // Key events here are dropped; blink is pinned on while waiting.
        restart = 1'b1;
        if (valid_q && bus.move_ready) begin
          valid_d = 1'b0;
          state_d = StEdit;
        end
      end
      default: state_d = StEdit;
    endcase

    // A restart outranks a terminal count landing in the same cycle.
    if (restart) begin
      blink_d = 1'b1;
      cnt_d   = '0;
    end else if (bus.en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.cur_x      = x_q;
  assign bus.cur_y      = y_q;
  assign bus.cur_blink  = blink_q;
  assign bus.move_valid = valid_q;
  assign bus.move_x     = mx_q;
  assign bus.move_y     = my_q;

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// Self-checking bench for key_cursor_ctrl (blink divider shortened to 4).
module tb_key_cursor_ctrl;

  localparam int BS = 15;
  localparam int BD = 4;
  localparam logic [3:0] K_UP = 4'h2, K_DOWN = 4'h8, K_LEFT = 4'h4, K_RIGHT = 4'h6;
  localparam logic [3:0] K_OK = 4'h5, K_HOME = 4'h0;

  logic clk = 1'b0;
  logic rst_p;

  key_cursor_if #(.COORD_W(4)) bus ();

  key_cursor_ctrl #(.BLINK_DIV(BD)) dut (
    .clk_100M (clk),
    .rst_p    (rst_p),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cursor position, pending flag, offered move and the number
  // of enabled cycles since the blink phase last restarted.
  int m_x, m_y, m_mx, m_my, m_since;
  bit m_pend, m_prev;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = BS / 2; m_y = BS / 2; m_mx = 0; m_my = 0;
    m_since = 0; m_pend = 0; m_prev = 0;
  endtask

  task automatic model_step();
    bit evt, restart;
    if (rst_p) begin
      model_reset();
      return;
    end
    evt     = bus.key_trick && !m_prev && bus.en;
    m_prev  = bus.key_trick;
    restart = 0;
    if (m_pend) begin
      restart = 1;
      if (bus.move_ready) m_pend = 0;
    end else if (evt) begin
      case (bus.key_code)
        K_LEFT:  begin m_x = (m_x + BS - 1) % BS; restart = 1; end
        K_RIGHT: begin m_x = (m_x + 1) % BS;      restart = 1; end
        K_UP:    begin m_y = (m_y + BS - 1) % BS; restart = 1; end
        K_DOWN:  begin m_y = (m_y + 1) % BS;      restart = 1; end
        K_HOME:  begin m_x = BS / 2; m_y = BS / 2; restart = 1; end
        K_OK: if (bus.turn_en) begin
          m_mx = m_x; m_my = m_y; m_pend = 1; restart = 1;
        end
        default: ;
      endcase
    end
    if (restart) m_since = 0;
    else if (bus.en) m_since++;
  endtask

  task automatic model_compare();
    check("model cur_x", int'(bus.cur_x), m_x);
    check("model cur_y", int'(bus.cur_y), m_y);
    check("model move_valid", int'(bus.move_valid), int'(m_pend));
    check("model move_x", int'(bus.move_x), m_mx);
    check("model move_y", int'(bus.move_y), m_my);
    check("model cur_blink", int'(bus.cur_blink), int'(((m_since / BD) % 2) == 0));
  endtask

  // One clock: model advances on the active edge, outputs compared on the far edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_compare();
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_code  = code;
    bus.key_trick = 1'b1;
    tick();
    bus.key_trick = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [3:0] code;
    logic       turn;
    int         ex;
    int         ey;
    logic       ev;
  } vec_t;

  vec_t vecs [0:20];

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = '{K_LEFT, 1'b1, (i < 7) ? 6 - i : 14, 7, 1'b0};
    for (int i = 0; i < 8; i++) vecs[8 + i] = '{K_UP, 1'b1, 14, (i < 7) ? 6 - i : 14, 1'b0};
    vecs[16] = '{K_DOWN,  1'b1, 14, 0, 1'b0};
    vecs[17] = '{K_RIGHT, 1'b1, 0,  0, 1'b0};
    vecs[18] = '{K_HOME,  1'b1, 7,  7, 1'b0};
    vecs[19] = '{K_OK,    1'b0, 7,  7, 1'b0};
    vecs[20] = '{4'hF,    1'b1, 7,  7, 1'b0};

    bus.en = 1'b1; bus.key_code = 4'h0; bus.key_trick = 1'b0;
    bus.turn_en = 1'b0; bus.move_ready = 1'b0;
    rst_p = 1'b1;
    model_reset();
    tick();
    tick();
    rst_p = 1'b0;
    check("reset cur_x", int'(bus.cur_x), 7);
    check("reset cur_y", int'(bus.cur_y), 7);
    check("reset cur_blink", int'(bus.cur_blink), 1);
    check("reset move_valid", int'(bus.move_valid), 0);
    check("reset move_x", int'(bus.move_x), 0);

    // Table: wrap-around on both axes, home, gated OK, unmapped code.
    foreach (vecs[i]) begin
      bus.turn_en = vecs[i].turn;
      press(vecs[i].code);
      check($sformatf("vec%0d cur_x", i), int'(bus.cur_x), vecs[i].ex);
      check($sformatf("vec%0d cur_y", i), int'(bus.cur_y), vecs[i].ey);
      check($sformatf("vec%0d move_valid", i), int'(bus.move_valid), int'(vecs[i].ev));
    end

    // Held strobe gives a single step.
    bus.key_code = K_RIGHT;
    bus.key_trick = 1'b1;
    repeat (10) tick();
    bus.key_trick = 1'b0;
    tick();
    check("held key cur_x", int'(bus.cur_x), 8);

    // Move to (3,9), confirm, then stall the handshake under key traffic.
    repeat (5) press(K_LEFT);
    repeat (2) press(K_DOWN);
    bus.turn_en = 1'b1;
    press(K_OK);
    check("offer move_valid", int'(bus.move_valid), 1);
    check("offer move_x", int'(bus.move_x), 3);
    check("offer move_y", int'(bus.move_y), 9);
    repeat (10) press(K_RIGHT);
    check("stall cur_x", int'(bus.cur_x), 3);
    check("stall move_valid", int'(bus.move_valid), 1);
    check("stall move_x", int'(bus.move_x), 3);
    check("stall cur_blink", int'(bus.cur_blink), 1);
    bus.move_ready = 1'b1;
    tick();
    check("accept move_valid", int'(bus.move_valid), 0);
    tick();
    bus.move_ready = 1'b0;
    check("idle ready move_valid", int'(bus.move_valid), 0);
    press(K_RIGHT);
    check("edit again cur_x", int'(bus.cur_x), 4);

    // Asynchronous reset in the middle of a pending offer.
    press(K_OK);
    check("pending move_valid", int'(bus.move_valid), 1);
    #2 rst_p = 1'b1;
    #1;
    check("async rst move_valid", int'(bus.move_valid), 0);
    check("async rst cur_x", int'(bus.cur_x), 7);
    model_reset();
    tick();
    rst_p = 1'b0;
    tick();

    // OK without turn, then masked keys with the blink counter frozen.
    bus.turn_en = 1'b0;
    press(K_OK);
    check("no turn move_valid", int'(bus.move_valid), 0);
    bus.key_code = K_HOME; bus.key_trick = 1'b1;
    tick();
    bus.key_trick = 1'b0;
    tick();
    tick();
    bus.en = 1'b0;
    press(K_UP);
    repeat (8) tick();
    check("en low cur_y", int'(bus.cur_y), 7);
    check("en low cur_blink", int'(bus.cur_blink), 1);
    bus.en = 1'b1;
    tick();
    check("resume blink hi", int'(bus.cur_blink), 1);
    tick();
    check("resume blink lo", int'(bus.cur_blink), 0);

    // Free-running blink, then a key event landing on terminal count.
    bus.key_code = K_HOME; bus.key_trick = 1'b1;
    tick();
    bus.key_trick = 1'b0;
    for (int k = 1; k < 12; k++) begin
      tick();
      check($sformatf("blink k%0d", k), int'(bus.cur_blink), int'(((k / 4) % 2) == 0));
    end
    bus.key_trick = 1'b1;
    tick();
    bus.key_trick = 1'b0;
    repeat (3) tick();
    bus.key_code = K_RIGHT; bus.key_trick = 1'b1;
    tick();
    bus.key_trick = 1'b0;
    check("tc event blink", int'(bus.cur_blink), 1);
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("tc restart k%0d", k), int'(bus.cur_blink), int'(k < 4));
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 800; c++) begin
      int r;
      bus.key_trick  = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      case (r)
        0: bus.key_code = K_LEFT;
        1: bus.key_code = K_RIGHT;
        2: bus.key_code = K_UP;
        3: bus.key_code = K_DOWN;
        4, 5: bus.key_code = K_OK;
        6: bus.key_code = K_HOME;
        default: bus.key_code = 4'($urandom_range(0, 15));
      endcase
      bus.en         = ($urandom_range(0, 9) != 0);
      bus.turn_en    = ($urandom_range(0, 9) < 7);
      bus.move_ready = ($urandom_range(0, 9) < 3);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_cursor_ctrl.md
Name: key_cursor_ctrl

Overview:
- Sits directly downstream of matrix_keyboard_top on the Gobang board path.
- Consumes the 4-bit key_code / key_trick stream and maintains a cursor (x, y) on the BOARD_SIZE x BOARD_SIZE board.
- On the confirm key, it offers a move to the game logic over a valid/ready handshake.
- It also generates a cursor blink flag for the display stage.

Parameters:
- BOARD_SIZE, 15, board edge length in cells; legal coordinates 0..BOARD_SIZE-1.
- COORD_W, 4, coordinate width; must satisfy 2^COORD_W >= BOARD_SIZE.
- KEY_UP, 4'h2, key code for y-1.
- KEY_DOWN, 4'h8, key code for y+1.
- KEY_LEFT, 4'h4, key code for x-1.
- KEY_RIGHT, 4'h6, key code for x+1.
- KEY_OK, 4'h5, key code for confirm.
- KEY_HOME, 4'h0, key code that returns the cursor to the centre.
- BLINK_DIV, 25_000_000, clk_100M cycles per blink half-period.

Ports:
- clk_100M  input  1  system clock.
- rst_p  input  1  asynchronous, active-high reset.
- en  input  1  block enable; when low, key events are ignored and the blink counter holds.
- key_code  input  4  key code from the keyboard stage; sampled only on a key event.
- key_trick  input  1  key strobe; a key event is a 0->1 edge detected internally.
- turn_en  input  1  high when the local player may move; gates KEY_OK only.
- cur_x  output  COORD_W  cursor column.
- cur_y  output  COORD_W  cursor row.
- cur_blink  output  1  cursor visibility flag.
- move_valid  output  1  move offered to the game logic.
- move_x  output  COORD_W  offered column.
- move_y  output  COORD_W  offered row.
- move_ready  input  1  game logic accepts the move.

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - cur_x = cur_y = BOARD_SIZE/2 (7 for the default).
  - cur_blink = 1.
  - move_valid = 0; move_x = move_y = 0.
  - Blink counter = 0; edge-detect register = 0; state = EDIT.
- Key event: key_trick registered once; event = key_trick & ~key_trick_d & en. key_code is sampled in the same cycle.
- State EDIT:
  - Direction keys move the cursor one step, with wrap-around: x = 0 with LEFT -> BOARD_SIZE-1; x = BOARD_SIZE-1 with RIGHT -> 0. y behaves the same way.
  - cur_x/cur_y update 1 cycle after the event cycle (the cycle after the key_trick rising edge is registered).
  - KEY_HOME sets both coordinates to BOARD_SIZE/2.
  - KEY_OK with turn_en = 1: latch move_x/move_y = cur_x/cur_y, set move_valid = 1 on the next cycle, go to PENDING.
  - KEY_OK with turn_en = 0: ignored.
  - Unmapped codes: ignored.
- State PENDING:
  - move_valid stays high; move_x/move_y are stable; all key events are ignored and dropped, not queued.
  - On a cycle with move_valid & move_ready: move_valid = 0 next cycle, return to EDIT.
  - move_ready while move_valid = 0 has no effect.
- en low while in PENDING: the handshake still completes; only new key events are masked.
- Blink:
  - Counter counts 0..BLINK_DIV-1 while en = 1; at terminal count it wraps to 0 and cur_blink toggles.
  - Any cursor-changing event (move or home) forces cur_blink = 1 and clears the counter.
  - In PENDING, cur_blink is held at 1.
- Width: coordinate arithmetic is done in COORD_W bits. Wrap is by explicit compare, never by modulo overflow.
- Simultaneous cases:
  - A key event in the same cycle as move_ready acceptance is dropped.
  - A key event and a blink terminal count in the same cycle: the event wins, so cur_blink = 1 and the counter clears.

Test Plan:
1. Reset, then release with BOARD_SIZE = 15 -> cur_x = 7, cur_y = 7, cur_blink = 1, move_valid = 0. Assert rst_p mid-PENDING -> move_valid drops immediately (asynchronously), without waiting for a clock edge.
2. Eight LEFT pulses starting from x = 7 -> x steps 6..0, then wraps to 14. Then one DOWN from y = 14 -> y = 0.
3. Hold key_trick high for 10 cycles with code KEY_RIGHT -> exactly one step (x 7 -> 8).
4. KEY_OK with turn_en = 1 at (3, 9) -> move_valid = 1 with move_x = 3, move_y = 9. Then hold move_ready = 0 for 20 cycles while sending RIGHT keys -> cursor and move stay unchanged. Then one cycle of move_ready = 1 -> move_valid = 0 and state is EDIT.
5. KEY_OK with turn_en = 0 -> move_valid stays 0. en = 0 with KEY_UP -> no cursor change and the blink counter frozen.
6. BLINK_DIV overridden to 4 -> cur_blink toggles every 4 cycles. Send a key event on a terminal-count cycle -> cur_blink = 1 and the counter restarts from 0.
